// File: rtl/timer_sequencer.sv
// Command sequencer for the seconds timer: queues interval values and issues them one at a time,
// waiting for the timer's expiry pulse, with a watchdog and a safe abort path.
module timer_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter logic [23:0] WDOG  = 24'd8421376
) (
    input  logic          Clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          go,
    input  logic          abort,
    input  logic          clr_err,
    input  logic          pluse,
    output logic          start,
    output logic [7:0]    alarm,
    output logic          evt,
    output logic          done,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          err_ovf,
    output logic          err_wdog
);

    typedef enum logic [2:0] {StIdle, StLoad, StFire, StWait, StGap, StFlush} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic [7:0]    alarm_q;
    logic [23:0]   wdog_q, wdog_d, wdog_inc;
    logic          done_q, done_d;
    logic          err_ovf_q, err_wdog_q;
    logic          push, pop, flush, wdog_set, wdog_exp, ovf;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (AW+1)'(DEPTH));
    assign wdog_inc = wdog_q + 24'd1;
    assign wdog_exp = (wdog_inc >= WDOG);
    // A write is judged against the registered full flag; a same-cycle pop does not make room.
    assign push     = wr_en && !full && !flush;
    assign ovf      = wr_en && full;

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        flush    = 1'b0;
        pop      = 1'b0;
        done_d   = 1'b0;
        wdog_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (abort) begin
                    flush = 1'b1;
                end else if (go && !empty) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end else begin
                    pop     = 1'b1;
                    state_d = StFire;
                end
            end
            StFire: begin
                wdog_d = '0;
                if (abort) begin
                    flush   = 1'b1;
                    state_d = StFlush;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                wdog_d = wdog_inc;
                if (abort) begin
                    flush   = 1'b1;
                    state_d = StFlush;
                end else if (pluse) begin
                    state_d = StGap;
                end else if (wdog_exp) begin
                    wdog_set = 1'b1;
                    flush    = 1'b1;
                    state_d  = StIdle;
                end
            end
            StGap: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end else if (!empty) begin
                    state_d = StLoad;
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StFlush: begin
                // The timer is still running; hold off until it finishes or the watchdog gives up.
                wdog_d = wdog_inc;
                flush  = abort;
                if (pluse) begin
                    state_d = StIdle;
                end else if (wdog_exp) begin
                    wdog_set = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            alarm_q    <= '0;
            wdog_q     <= '0;
            done_q     <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_wdog_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            done_q  <= done_d;
            if (pop) begin
                alarm_q <= mem[rd_ptr_q];
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                if (push && !pop)      level_q <= level_q + (AW+1)'(1);
                else if (pop && !push) level_q <= level_q - (AW+1)'(1);
            end
            if (ovf)          err_ovf_q <= 1'b1;
            else if (clr_err) err_ovf_q <= 1'b0;
            if (wdog_set)     err_wdog_q <= 1'b1;
            else if (clr_err) err_wdog_q <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign start    = (state_q == StFire);
    assign evt      = (state_q == StGap);
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign alarm    = alarm_q;
    assign level    = level_q;
    assign err_ovf  = err_ovf_q;
    assign err_wdog = err_wdog_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed self-checking bench for timer_sequencer (DEPTH=8, WDOG=20).
module tb_timer_sequencer;

    logic       Clk = 1'b0;
    logic       rst, wr_en, go, abort, clr_err, pluse;
    logic [7:0] wr_data;
    logic       start, evt, done, busy, full, empty, err_ovf, err_wdog;
    logic [7:0] alarm;
    logic [3:0] level;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int evt_cnt = 0;
    int done_cnt = 0;

    timer_sequencer #(.DEPTH(8), .AW(3), .WDOG(24'd20)) dut (
        .Clk(Clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .go(go), .abort(abort),
        .clr_err(clr_err), .pluse(pluse), .start(start), .alarm(alarm), .evt(evt),
        .done(done), .busy(busy), .full(full), .empty(empty), .level(level),
        .err_ovf(err_ovf), .err_wdog(err_wdog)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (start) start_cnt <= start_cnt + 1;
        if (evt)   evt_cnt   <= evt_cnt + 1;
        if (done)  done_cnt  <= done_cnt + 1;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        wr_en = 1'b1; wr_data = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] exp_v, got_v;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        exp_v = {1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        got_v = {start, alarm, evt, done, busy, empty, full, level, err_ovf, err_wdog};
        tests++;
        if (got_v !== exp_v) begin
            fails++; $display("FAIL reset_outputs got %h exp %h", got_v, exp_v);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vals [3];
        int s0, e0, d0;
        vals = '{8'd3, 8'd1, 8'd2};
        push(8'd3); push(8'd1); push(8'd2);
        tests++;
        if (level !== 4'd3) begin fails++; $display("FAIL basic_level got %0d exp 3", level); end
        s0 = start_cnt; e0 = evt_cnt; d0 = done_cnt;
        go = 1'b1; step(); go = 1'b0;
        tests++;
        if (start !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL basic_load got start=%b busy=%b exp 0 1", start, busy);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (start !== 1'b1 || alarm !== vals[i]) begin
                fails++;
                $display("FAIL basic_start%0d got start=%b alarm=%0d exp 1 %0d", i, start, alarm,
                         vals[i]);
            end
            for (int k = 1; k <= 4; k++) begin
                step();
                tests++;
                if (start !== 1'b0 || alarm !== vals[i]) begin
                    fails++;
                    $display("FAIL basic_hold%0d got start=%b alarm=%0d exp 0 %0d", i, start,
                             alarm, vals[i]);
                end
            end
            step();
            pluse = 1'b1; step(); pluse = 1'b0;
            tests++;
            if (evt !== 1'b1) begin fails++; $display("FAIL basic_evt%0d got %b exp 1", i, evt); end
            step();
            if (i < 2) begin
                step();
            end else begin
                tests++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL basic_done got done=%b busy=%b exp 1 0", done, busy);
                end
            end
        end
        step();
        tests++;
        if (start_cnt - s0 != 3 || evt_cnt - e0 != 3 || done_cnt - d0 != 1 || empty !== 1'b1) begin
            fails++;
            $display("FAIL basic_counts got start=%0d evt=%0d done=%0d empty=%b exp 3 3 1 1",
                     start_cnt - s0, evt_cnt - e0, done_cnt - d0, empty);
        end
    endtask

    task automatic test_overflow();
        int s0;
        for (int i = 0; i < 9; i++) push(8'(10 + i));
        tests++;
        if (full !== 1'b1 || level !== 4'd8 || err_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_status got full=%b level=%0d err=%b exp 1 8 1", full, level, err_ovf);
        end
        wr_en = 1'b1; wr_data = 8'd77; clr_err = 1'b1; step(); wr_en = 1'b0; clr_err = 1'b0;
        tests++;
        if (err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set_wins got %b exp 1", err_ovf); end
        clr_err = 1'b1; step(); clr_err = 1'b0;
        tests++;
        if (err_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b exp 0", err_ovf); end
        s0 = start_cnt;
        go = 1'b1; step(); go = 1'b0; step();
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (start !== 1'b1 || alarm !== 8'(10 + i)) begin
                fails++;
                $display("FAIL ovf_issue%0d got start=%b alarm=%0d exp 1 %0d", i, start, alarm,
                         10 + i);
            end
            step();
            pluse = 1'b1; step(); pluse = 1'b0;
            step();
            if (i < 7) step();
        end
        tests++;
        if (done !== 1'b1 || empty !== 1'b1) begin
            fails++; $display("FAIL ovf_done got done=%b empty=%b exp 1 1", done, empty);
        end
        step();
        tests++;
        if (start_cnt - s0 != 8) begin
            fails++; $display("FAIL ovf_count got %0d exp 8", start_cnt - s0);
        end
    endtask

    task automatic test_abort();
        int s0, e0, d0;
        push(8'd5); push(8'd6); push(8'd7); push(8'd8);
        s0 = start_cnt; e0 = evt_cnt; d0 = done_cnt;
        go = 1'b1; step(); go = 1'b0;
        step(); step();
        abort = 1'b1; step(); abort = 1'b0;
        tests++;
        if (level !== 4'd0 || busy !== 1'b1 || empty !== 1'b1) begin
            fails++;
            $display("FAIL abort_flush got level=%0d busy=%b empty=%b exp 0 1 1", level, busy, empty);
        end
        step(); step(); step();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL abort_hold got busy=%b exp 1", busy); end
        pluse = 1'b1; step(); pluse = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle got busy=%b exp 0", busy); end
        step(); step(); step();
        tests++;
        if (start_cnt - s0 != 1 || evt_cnt != e0 || done_cnt != d0) begin
            fails++;
            $display("FAIL abort_quiet got start=%0d evt=%0d done=%0d exp 1 0 0",
                     start_cnt - s0, evt_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_wdog();
        push(8'd7); push(8'd8);
        go = 1'b1; step(); go = 1'b0; step();
        tests++;
        if (start !== 1'b1) begin fails++; $display("FAIL wdog_start got %b exp 1", start); end
        for (int k = 1; k <= 20; k++) step();
        tests++;
        if (err_wdog !== 1'b0 || busy !== 1'b1 || level !== 4'd1) begin
            fails++;
            $display("FAIL wdog_before got err=%b busy=%b level=%0d exp 0 1 1", err_wdog, busy, level);
        end
        step();
        tests++;
        if (err_wdog !== 1'b1 || busy !== 1'b0 || level !== 4'd0) begin
            fails++;
            $display("FAIL wdog_expire got err=%b busy=%b level=%0d exp 1 0 0", err_wdog, busy, level);
        end
        clr_err = 1'b1; step(); clr_err = 1'b0;
        tests++;
        if (err_wdog !== 1'b0) begin fails++; $display("FAIL wdog_clear got %b exp 0", err_wdog); end
    endtask

    task automatic test_edge();
        int s0;
        s0 = start_cnt;
        go = 1'b1; step(); step(); step(); go = 1'b0; step();
        tests++;
        if (start_cnt != s0 || busy !== 1'b0) begin
            fails++; $display("FAIL edge_go_empty got starts=%0d busy=%b exp 0 0", start_cnt - s0, busy);
        end
        push(8'd0);
        go = 1'b1; step(); go = 1'b0; step();
        tests++;
        if (start !== 1'b1 || alarm !== 8'd0) begin
            fails++; $display("FAIL edge_zero_start got start=%b alarm=%0d exp 1 0", start, alarm);
        end
        step();
        pluse = 1'b1; step(); pluse = 1'b0;
        tests++;
        if (evt !== 1'b1) begin fails++; $display("FAIL edge_zero_evt got %b exp 1", evt); end
        step();
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL edge_zero_done got %b exp 1", done); end
        for (int i = 0; i < 8; i++) push(8'(20 + i));
        go = 1'b1; step(); go = 1'b0;
        wr_en = 1'b1; wr_data = 8'd99; step(); wr_en = 1'b0;
        tests++;
        if (err_ovf !== 1'b1 || level !== 4'd7 || alarm !== 8'd20) begin
            fails++;
            $display("FAIL edge_pop_ovf got err=%b level=%0d alarm=%0d exp 1 7 20", err_ovf, level,
                     alarm);
        end
        abort = 1'b1; step(); abort = 1'b0;
        pluse = 1'b1; step(); pluse = 1'b0;
        clr_err = 1'b1; step(); clr_err = 1'b0;
        tests++;
        if (busy !== 1'b0 || empty !== 1'b1 || err_ovf !== 1'b0) begin
            fails++;
            $display("FAIL edge_cleanup got busy=%b empty=%b err=%b exp 0 1 0", busy, empty, err_ovf);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp_v, got_v;
        push(8'd3); push(8'd4);
        go = 1'b1; step(); go = 1'b0; step(); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        exp_v = {1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        got_v = {start, alarm, evt, done, busy, empty, full, level, err_ovf, err_wdog};
        tests++;
        if (got_v !== exp_v) begin
            fails++; $display("FAIL rstmid_outputs got %h exp %h", got_v, exp_v);
        end
        push(8'd9);
        go = 1'b1; step(); go = 1'b0; step();
        tests++;
        if (start !== 1'b1 || alarm !== 8'd9) begin
            fails++; $display("FAIL rstmid_start got start=%b alarm=%0d exp 1 9", start, alarm);
        end
        step();
        pluse = 1'b1; step(); pluse = 1'b0;
        tests++;
        if (evt !== 1'b1) begin fails++; $display("FAIL rstmid_evt got %b exp 1", evt); end
        step();
        tests++;
        if (done !== 1'b1 || empty !== 1'b1) begin
            fails++; $display("FAIL rstmid_done got done=%b empty=%b exp 1 1", done, empty);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'd0; go = 1'b0; abort = 1'b0;
        clr_err = 1'b0; pluse = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_abort();
        test_wdog();
        test_edge();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
